fifo_stream_out: RTL and testbench

- Downstream drain stage for the team's synchronous FIFO.
- Issues DEQ against the FIFO's EMPTY flag and captures the registered read data one cycle later.
- Re-presents the words as a valid/ready stream, grouped into fixed-length packets with a LAST marker.
- A 3-entry skid buffer absorbs the one-cycle read latency. This gives full throughput with no combinational path from OUT_READY to F_DEQ.

---
 rtl/fifo_stream_out.sv | 95 +++++++++
 tb/tb_fifo_stream_out.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_out.sv
// Drains a synchronous FIFO into a packetised valid/ready stream through a
// 3-entry skid buffer that hides the FIFO's one-cycle read latency.
module fifo_stream_out #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned PKT_LEN = 4,
  parameter int unsigned W_BEAT  = 2
) (
  input  logic             CLK,
  input  logic             RST_X,
  input  logic             F_EMPTY,
  input  logic [WIDTH-1:0] F_DOUT,
  output logic             F_DEQ,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic             OUT_LAST
);

  localparam int unsigned DEPTH = 3;
  localparam int unsigned W_PTR = 2;
  localparam int unsigned W_OCC = 2;
  localparam int unsigned W_SUM = 3;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [W_OCC-1:0]  occ_q, occ_d;
  logic              pend_q, pend_d;
  logic [W_PTR-1:0]  head_q, head_d;
  logic [W_PTR-1:0]  tail_q, tail_d;
  logic [W_BEAT-1:0] beat_q, beat_d;

  logic [W_SUM-1:0]  occ_pend_c;
  logic              deq_c;
  logic              cap_c;
  logic              valid_c;
  logic              pop_c;
  logic              last_beat_c;

  function automatic logic [W_PTR-1:0] ptr_inc(input logic [W_PTR-1:0] p);
    return (p == W_PTR'(DEPTH - 1)) ? '0 : p + W_PTR'(1);
  endfunction

  // Request/accept decisions and next-state; DEQ never looks at OUT_READY.
  always_comb begin
    occ_pend_c  = W_SUM'(occ_q) + W_SUM'(pend_q);
    deq_c       = RST_X && !F_EMPTY && (occ_pend_c < W_SUM'(DEPTH));
    cap_c       = pend_q;
    valid_c     = (occ_q != '0);
    pop_c       = valid_c && OUT_READY;
    last_beat_c = (beat_q == W_BEAT'(PKT_LEN - 1));

    pend_d = deq_c;
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    beat_d = beat_q;

    if (cap_c) tail_d = ptr_inc(tail_q);
    if (pop_c) begin
      head_d = ptr_inc(head_q);
      beat_d = last_beat_c ? '0 : beat_q + W_BEAT'(1);
    end
    if (cap_c && !pop_c) occ_d = occ_q + W_OCC'(1);
    else if (!cap_c && pop_c) occ_d = occ_q - W_OCC'(1);
  end

  always_ff @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      occ_q  <= '0;
      pend_q <= 1'b0;
      head_q <= '0;
      tail_q <= '0;
      beat_q <= '0;
    end else begin
      occ_q  <= occ_d;
      pend_q <= pend_d;
      head_q <= head_d;
      tail_q <= tail_d;
      beat_q <= beat_d;
    end
  end

  // Payload storage carries no reset; occupancy alone qualifies it.
  always_ff @(posedge CLK) begin
    if (cap_c) mem_q[tail_q] <= F_DOUT;
  end

  assign F_DEQ     = deq_c;
  assign OUT_VALID = valid_c;
  assign OUT_DATA  = valid_c ? mem_q[head_q] : '0;
  assign OUT_LAST  = valid_c && last_beat_c;

  a_no_overflow: assert property (@(posedge CLK) disable iff (!RST_X)
    occ_pend_c <= W_SUM'(DEPTH));

endmodule

// File: tb/tb_fifo_stream_out.sv
// Directed bench for fifo_stream_out against a behavioural depth-5 FIFO and
// an in-order scoreboard with packet-position tracking.
module tb_fifo_stream_out;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NVEC  = 17;

  logic             CLK = 1'b0;
  logic             RST_X;
  logic             F_EMPTY;
  logic [WIDTH-1:0] F_DOUT;
  logic             F_DEQ;
  logic [WIDTH-1:0] OUT_DATA;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic             OUT_LAST;

  int checks = 0;
  int errors = 0;

  fifo_stream_out #(.WIDTH(WIDTH), .PKT_LEN(4), .W_BEAT(2)) dut (
    .CLK(CLK), .RST_X(RST_X), .F_EMPTY(F_EMPTY), .F_DOUT(F_DOUT),
    .F_DEQ(F_DEQ), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .OUT_LAST(OUT_LAST)
  );

  always #5 CLK = ~CLK;

  // Behavioural FIFO, depth 5, registered read data, reset by RST_X.
  logic [WIDTH-1:0] src_q  [$];
  logic [WIDTH-1:0] fifo_q [$];
  logic             fifo_empty = 1'b1;
  logic             hold_ne = 1'b0;
  logic [WIDTH-1:0] dout_r = '0;
  assign F_EMPTY = hold_ne ? 1'b0 : fifo_empty;
  assign F_DOUT  = dout_r;

  always @(posedge CLK or negedge RST_X) begin
    if (!RST_X) begin
      fifo_q.delete();
      dout_r     <= '0;
      fifo_empty <= 1'b1;
    end else begin
      if (F_DEQ && fifo_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL deq_on_empty act=1 exp=0");
      end
      if (F_DEQ && fifo_q.size() > 0) dout_r <= fifo_q.pop_front();
      else dout_r <= '0;
      while (src_q.size() > 0 && fifo_q.size() < 5) fifo_q.push_back(src_q.pop_front());
      fifo_empty <= (fifo_q.size() == 0);
    end
  end

  // Scoreboard: order, packet position and hold-while-stalled.
  logic [WIDTH-1:0] exp_q [$];
  int               sb_cnt = 0;
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data;
  logic             prev_last;

  always @(negedge CLK) begin
    if (!RST_X) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!(OUT_VALID && OUT_DATA == prev_data && OUT_LAST == prev_last)) begin
          errors++;
          $display("FAIL hold act=v%0b d%0h l%0b exp=v1 d%0h l%0b",
                   OUT_VALID, OUT_DATA, OUT_LAST, prev_data, prev_last);
        end
      end
      if (OUT_VALID && OUT_READY) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra act=%0h exp=none", OUT_DATA);
        end else begin
          logic [WIDTH-1:0] e;
          logic             el;
          e  = exp_q.pop_front();
          el = ((sb_cnt % 4) == 3);
          if (OUT_DATA !== e || OUT_LAST !== el) begin
            errors++;
            $display("FAIL sb_word act=%0h/%0b exp=%0h/%0b", OUT_DATA, OUT_LAST, e, el);
          end
        end
        sb_cnt++;
      end
      prev_stall = OUT_VALID && !OUT_READY;
      prev_data  = OUT_DATA;
      prev_last  = OUT_LAST;
    end
  end

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic push_words(input int first, input int n);
    for (int k = 0; k < n; k++) begin
      src_q.push_back(WIDTH'(first + k));
      exp_q.push_back(WIDTH'(first + k));
    end
  endtask

  task automatic do_reset();
    @(posedge CLK); #1;
    RST_X = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    src_q.delete();
    exp_q.delete();
    sb_cnt = 0;
    RST_X  = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic wait_sb(input int n, input int budget, input string name);
    for (int k = 0; k < budget && sb_cnt < n; k++) @(posedge CLK);
    #1;
    chk(name, WIDTH'(sb_cnt), WIDTH'(n));
  endtask

  typedef struct {
    logic             rdy;
    logic             deq;
    logic             vld;
    logic [WIDTH-1:0] data;
    logic             last;
  } vec_t;

  vec_t tbl [NVEC];

  function automatic void set_vec(input int i, input logic rdy, input logic deq,
                                  input logic vld, input int data, input logic last);
    tbl[i].rdy  = rdy;
    tbl[i].deq  = deq;
    tbl[i].vld  = vld;
    tbl[i].data = WIDTH'(data);
    tbl[i].last = last;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;

    // Backpressure scenario from cycle 0 = edge the FIFO receives 1..5.
    for (int i = 0; i < 2; i++)  set_vec(i, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    set_vec(2, 1'b0, 1'b1, 1'b1, 1, 1'b0);
    for (int i = 3; i < 10; i++) set_vec(i, 1'b0, 1'b0, 1'b1, 1, 1'b0);
    set_vec(10, 1'b1, 1'b0, 1'b1, 1, 1'b0);
    set_vec(11, 1'b1, 1'b1, 1'b1, 2, 1'b0);
    set_vec(12, 1'b1, 1'b1, 1'b1, 3, 1'b0);
    set_vec(13, 1'b1, 1'b0, 1'b1, 4, 1'b1);
    set_vec(14, 1'b1, 1'b0, 1'b1, 5, 1'b0);
    set_vec(15, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    set_vec(16, 1'b1, 1'b0, 1'b0, 0, 1'b0);

    // Reset held with a non-empty FIFO flag.
    RST_X     = 1'b0;
    OUT_READY = 1'b1;
    hold_ne   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("rst_deq",   WIDTH'(F_DEQ),     '0);
      chk("rst_valid", WIDTH'(OUT_VALID), '0);
      chk("rst_last",  WIDTH'(OUT_LAST),  '0);
      chk("rst_data",  OUT_DATA,          '0);
    end
    @(posedge CLK); #1;
    RST_X = 1'b1;
    #1;
    chk("rel_deq", WIDTH'(F_DEQ), WIDTH'(1));
    hold_ne = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // Streaming 1..8 at full rate.
    push_words(1, 8);
    for (int k = 0; k < 20 && !OUT_VALID; k++) @(negedge CLK);
    chk("stream_first", WIDTH'(OUT_VALID), WIDTH'(1));
    for (int k = 0; k < 7; k++) begin
      @(negedge CLK);
      chk($sformatf("stream_gap%0d", k), WIDTH'(OUT_VALID), WIDTH'(1));
    end
    @(negedge CLK);
    chk("stream_end", WIDTH'(OUT_VALID), '0);
    chk("stream_cnt", WIDTH'(sb_cnt), WIDTH'(8));
    repeat (3) @(posedge CLK);
    #1;

    // Backpressure table.
    OUT_READY = 1'b0;
    push_words(1, 5);
    for (int i = 0; i < NVEC; i++) begin
      @(posedge CLK); #1;
      OUT_READY = tbl[i].rdy;
      @(negedge CLK);
      chk($sformatf("bp%0d_deq", i),   WIDTH'(F_DEQ),     WIDTH'(tbl[i].deq));
      chk($sformatf("bp%0d_valid", i), WIDTH'(OUT_VALID), WIDTH'(tbl[i].vld));
      chk($sformatf("bp%0d_data", i),  OUT_DATA,          tbl[i].data);
      chk($sformatf("bp%0d_last", i),  WIDTH'(OUT_LAST),  WIDTH'(tbl[i].last));
    end
    chk("bp_drained", WIDTH'(exp_q.size()), '0);

    // Alternating ready over 12 words.
    do_reset();
    push_words(1, 12);
    for (int k = 0; k < 200 && sb_cnt < 12; k++) begin
      @(posedge CLK); #1;
      OUT_READY = ~OUT_READY;
    end
    @(posedge CLK); #1;
    OUT_READY = 1'b1;
    chk("alt_cnt",  WIDTH'(sb_cnt),       WIDTH'(12));
    chk("alt_left", WIDTH'(exp_q.size()), '0);
    repeat (3) @(posedge CLK);
    #1;

    // Single word into an empty FIFO.
    push_words(7, 1);
    @(posedge CLK);
    @(negedge CLK);
    chk("emp_c0_deq",   WIDTH'(F_DEQ),     WIDTH'(1));
    chk("emp_c0_valid", WIDTH'(OUT_VALID), '0);
    @(negedge CLK);
    chk("emp_c1_deq",   WIDTH'(F_DEQ),     '0);
    chk("emp_c1_valid", WIDTH'(OUT_VALID), '0);
    @(negedge CLK);
    chk("emp_c2_valid", WIDTH'(OUT_VALID), WIDTH'(1));
    chk("emp_c2_data",  OUT_DATA,          WIDTH'(7));
    chk("emp_c2_last",  WIDTH'(OUT_LAST),  '0);
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge CLK);
      if (F_DEQ) pulses++;
    end
    chk("emp_valid_fall", WIDTH'(OUT_VALID), '0);
    chk("emp_no_deq",     WIDTH'(pulses),    '0);

    // Asynchronous reset in the middle of a packet.
    do_reset();
    OUT_READY = 1'b0;
    push_words(31, 8);
    for (int k = 0; k < 20 && !OUT_VALID; k++) begin
      @(posedge CLK); #1;
    end
    OUT_READY = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    OUT_READY = 1'b0;
    chk("mid_beats", WIDTH'(sb_cnt), WIDTH'(2));
    @(negedge CLK);
    chk("mid_pre_valid", WIDTH'(OUT_VALID), WIDTH'(1));
    #2;
    RST_X = 1'b0;
    #1;
    chk("mid_valid", WIDTH'(OUT_VALID), '0);
    chk("mid_last",  WIDTH'(OUT_LAST),  '0);
    chk("mid_deq",   WIDTH'(F_DEQ),     '0);
    chk("mid_data",  OUT_DATA,          '0);
    src_q.delete();
    exp_q.delete();
    sb_cnt = 0;
    repeat (2) @(posedge CLK);
    #1;
    RST_X     = 1'b1;
    OUT_READY = 1'b1;
    push_words(41, 8);
    wait_sb(8, 100, "post_rst_cnt");
    repeat (2) @(posedge CLK);
    #1;
    chk("post_rst_left", WIDTH'(exp_q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
